// File: rtl/sisc_pkg.sv
// Shared types and constants for the SISC front end.
// Fetch FSM encoding and instruction defaults.
package sisc_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_INST_W = 32;

  localparam logic [31:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_npc.sv
// Next-PC selection for the fetch stage.
// Sequential, absolute or PC-relative; wraps modulo 2^ADDR_W.
module fetch_npc
  import sisc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              br_sel,
  input  logic              br_rel,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] npc
);

  logic [ADDR_W-1:0] seq_pc;

  assign seq_pc = pc + ADDR_W'(1);

  // Pick the next PC; the offset is already ADDR_W wide so wrap is sext
  always_comb begin
    npc = seq_pc;
    unique case (1'b1)
      !br_sel:           npc = seq_pc;
      br_sel && br_rel:  npc = seq_pc + br_target;
      br_sel && !br_rel: npc = br_target;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, talks to imem.
// START -> FETCH -> HOLD, back to FETCH on next_req.
module fetch_unit
  import sisc_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                INST_W   = DEF_INST_W
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              next_req,
  input  logic              br_sel,
  input  logic              br_rel,
  input  logic [ADDR_W-1:0] br_target,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [INST_W-1:0] im_data,
  output logic [INST_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] npc;
  logic              req_d;
  logic              valid_d;
  logic [INST_W-1:0] ir_d;

  fetch_npc #(
    .ADDR_W(ADDR_W)
  ) u_npc (
    .pc       (pc),
    .br_sel   (br_sel),
    .br_rel   (br_rel),
    .br_target(br_target),
    .npc      (npc)
  );

  // Next-state and next-output logic; everything holds by default
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    addr_d  = im_addr;
    req_d   = im_req;
    valid_d = ir_valid;
    ir_d    = ir;
    case (state_q)
      ST_START: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
        addr_d  = pc;
      end
      ST_FETCH: begin
        if (im_req && im_ack) begin
          ir_d    = im_data;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (next_req) begin
          pc_d    = npc;
          addr_d  = npc;
          req_d   = 1'b1;
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_START;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any fetch in flight
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q  <= ST_START;
      pc       <= RESET_PC;
      im_addr  <= RESET_PC;
      im_req   <= 1'b0;
      ir       <= INST_W'(NOP_INST);
      ir_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc       <= pc_d;
      im_addr  <= addr_d;
      im_req   <= req_d;
      ir       <= ir_d;
      ir_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Memory responder and PC model live in the bench.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        next_req = 1'b0;
  logic        br_sel = 1'b0;
  logic        br_rel = 1'b0;
  logic [15:0] br_target = '0;
  logic        im_req;
  logic [15:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_data = '0;
  logic [31:0] ir;
  logic        ir_valid;
  logic [15:0] pc;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_pc = '0;
  int          delay = 0;
  int          cnt = 0;
  bit          auto_mem = 1'b0;

  fetch_unit dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .next_req (next_req),
    .br_sel   (br_sel),
    .br_rel   (br_rel),
    .br_target(br_target),
    .im_req   (im_req),
    .im_addr  (im_addr),
    .im_ack   (im_ack),
    .im_data  (im_data),
    .ir       (ir),
    .ir_valid (ir_valid),
    .pc       (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E37_79B1;
    return h ^ {a, ~a} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [15:0] ref_npc(
    input logic [15:0] p, input bit sel,
    input bit rel, input logic [15:0] tgt);
    int r;
    int off;
    off = int'(tgt);
    if (off >= 32768) off = off - 65536;
    if (!sel) r = int'(p) + 1;
    else if (!rel) r = int'(tgt);
    else r = int'(p) + 1 + off;
    r = ((r % 65536) + 65536) % 65536;
    return r[15:0];
  endfunction

  task automatic cyc();
    @(negedge clk);
    next_req = 1'b0;
    if (auto_mem) begin
      if (im_req && cnt >= delay) begin
        im_ack  = 1'b1;
        im_data = mem_word(im_addr);
        cnt     = 0;
      end else begin
        im_ack  = 1'b0;
        im_data = $urandom;
        cnt     = im_req ? cnt + 1 : 0;
      end
    end
  endtask

  task automatic issue(input bit sel, input bit rel,
                       input logic [15:0] tgt);
    next_req  = 1'b1;
    br_sel    = sel;
    br_rel    = rel;
    br_target = tgt;
    exp_pc    = ref_npc(exp_pc, sel, rel, tgt);
    cyc();
  endtask

  task automatic wait_ir(input int max);
    int n;
    n = 0;
    while (!ir_valid && n < max) begin
      cyc();
      n++;
    end
    checks++;
    if (ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_ir timeout got=%b want=1", ir_valid);
    end
  endtask

  task automatic test_reset();
    rst_f    = 1'b0;
    auto_mem = 1'b0;
    im_ack   = 1'b1;
    im_data  = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({pc, ir, im_req, ir_valid} !== 50'h0) begin
        errors++;
        $display("FAIL reset_hold pc=%h ir=%h req=%b v=%b want 0",
                 pc, ir, im_req, ir_valid);
      end
    end
    rst_f    = 1'b1;
    im_ack   = 1'b0;
    auto_mem = 1'b1;
    delay    = 0;
    cnt      = 0;
    exp_pc   = 16'h0;
    cyc();
    checks++;
    if (im_req !== 1'b1 || im_addr !== 16'h0 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL start req=%b addr=%h v=%b want 1 0000 0",
               im_req, im_addr, ir_valid);
    end
    cyc();
    checks++;
    if (ir !== mem_word(16'h0) || ir_valid !== 1'b1 || im_req !== 1'b0) begin
      errors++;
      $display("FAIL first_fetch ir=%h v=%b req=%b want %h 1 0",
               ir, ir_valid, im_req, mem_word(16'h0));
    end
  endtask

  task automatic test_sequential();
    delay = 0;
    for (int i = 1; i < 4; i++) begin
      issue(1'b0, 1'b0, 16'h0);
      checks++;
      if (im_req !== 1'b1 || im_addr !== 16'(i) || pc !== 16'(i)) begin
        errors++;
        $display("FAIL seq_addr%0d addr=%h pc=%h want %h", i,
                 im_addr, pc, 16'(i));
      end
      wait_ir(4);
      checks++;
      if (ir !== mem_word(16'(i))) begin
        errors++;
        $display("FAIL seq_ir%0d got=%h want=%h", i, ir,
                 mem_word(16'(i)));
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] old;
    old   = ir;
    delay = 3;
    issue(1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (im_req !== 1'b1 || im_addr !== exp_pc ||
          ir_valid !== 1'b0 || ir !== old) begin
        errors++;
        $display("FAIL wait%0d req=%b addr=%h v=%b ir=%h want 1 %h 0 %h",
                 k, im_req, im_addr, ir_valid, ir, exp_pc, old);
      end
      cyc();
    end
    checks++;
    if (ir_valid !== 1'b1 || ir !== mem_word(exp_pc)) begin
      errors++;
      $display("FAIL wait_done v=%b ir=%h want 1 %h",
               ir_valid, ir, mem_word(exp_pc));
    end
    delay = 0;
  endtask

  task automatic test_branches();
    issue(1'b0, 1'b0, 16'h0);
    wait_ir(4);
    checks++;
    if (pc !== 16'h0005) begin
      errors++;
      $display("FAIL br_setup pc=%h want 0005", pc);
    end
    issue(1'b1, 1'b0, 16'h0040);
    checks++;
    if (im_addr !== 16'h0040) begin
      errors++;
      $display("FAIL br_abs addr=%h want 0040", im_addr);
    end
    wait_ir(4);
    checks++;
    if (ir !== mem_word(16'h0040)) begin
      errors++;
      $display("FAIL br_abs_ir got=%h want=%h", ir, mem_word(16'h0040));
    end
    issue(1'b1, 1'b0, 16'h0005);
    wait_ir(4);
    issue(1'b1, 1'b1, 16'hFFFC);
    checks++;
    if (im_addr !== 16'h0002 || pc !== 16'h0002) begin
      errors++;
      $display("FAIL br_rel addr=%h pc=%h want 0002", im_addr, pc);
    end
    wait_ir(4);
    checks++;
    if (ir !== mem_word(16'h0002)) begin
      errors++;
      $display("FAIL br_rel_ir got=%h want=%h", ir, mem_word(16'h0002));
    end
    issue(1'b1, 1'b0, 16'hFFFF);
    wait_ir(4);
    issue(1'b1, 1'b1, 16'h0000);
    checks++;
    if (im_addr !== 16'h0000) begin
      errors++;
      $display("FAIL br_rel_wrap addr=%h want 0000", im_addr);
    end
    wait_ir(4);
    issue(1'b1, 1'b0, 16'hFFFF);
    wait_ir(4);
    issue(1'b0, 1'b0, 16'h0);
    checks++;
    if (im_addr !== 16'h0000 || pc !== 16'h0000) begin
      errors++;
      $display("FAIL seq_wrap addr=%h pc=%h want 0000", im_addr, pc);
    end
    wait_ir(4);
  endtask

  task automatic test_corners();
    logic [31:0] old;
    delay = 2;
    issue(1'b0, 1'b0, 16'h0);
    next_req  = 1'b1;
    br_sel    = 1'b1;
    br_rel    = 1'b0;
    br_target = 16'h1234;
    cyc();
    checks++;
    if (im_addr !== exp_pc || pc !== exp_pc) begin
      errors++;
      $display("FAIL nreq_in_fetch addr=%h pc=%h want %h",
               im_addr, pc, exp_pc);
    end
    wait_ir(6);
    checks++;
    if (ir !== mem_word(exp_pc)) begin
      errors++;
      $display("FAIL nreq_in_fetch_ir got=%h want=%h",
               ir, mem_word(exp_pc));
    end
    old      = ir;
    auto_mem = 1'b0;
    im_ack   = 1'b1;
    im_data  = 32'hDEAD_BEEF;
    cyc();
    cyc();
    checks++;
    if (ir !== old || ir_valid !== 1'b1 || im_req !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack ir=%h v=%b req=%b want %h 1 0",
               ir, ir_valid, im_req, old);
    end
    im_ack   = 1'b0;
    auto_mem = 1'b1;
    delay    = 0;
    issue(1'b0, 1'b0, 16'h0);
    next_req  = 1'b1;
    br_sel    = 1'b1;
    br_rel    = 1'b0;
    br_target = 16'h0077;
    cyc();
    checks++;
    if (ir_valid !== 1'b1 || pc !== exp_pc || im_req !== 1'b0 ||
        ir !== mem_word(exp_pc)) begin
      errors++;
      $display("FAIL ack_and_nreq v=%b pc=%h req=%b ir=%h want 1 %h 0 %h",
               ir_valid, pc, im_req, ir, exp_pc, mem_word(exp_pc));
    end
    delay = 5;
    issue(1'b0, 1'b0, 16'h0);
    cyc();
    rst_f = 1'b0;
    #1;
    checks++;
    if ({pc, ir, im_req, ir_valid} !== 50'h0) begin
      errors++;
      $display("FAIL async_rst pc=%h ir=%h req=%b v=%b want 0",
               pc, ir, im_req, ir_valid);
    end
    auto_mem = 1'b0;
    im_ack   = 1'b1;
    im_data  = 32'h0BAD_0BAD;
    cyc();
    cyc();
    checks++;
    if (ir !== 32'h0 || ir_valid !== 1'b0 || pc !== 16'h0) begin
      errors++;
      $display("FAIL late_ack ir=%h v=%b pc=%h want 0", ir, ir_valid, pc);
    end
    rst_f    = 1'b1;
    im_ack   = 1'b0;
    auto_mem = 1'b1;
    delay    = 0;
    cnt      = 0;
    exp_pc   = 16'h0;
    cyc();
    checks++;
    if (im_req !== 1'b1 || im_addr !== 16'h0) begin
      errors++;
      $display("FAIL restart req=%b addr=%h want 1 0000", im_req, im_addr);
    end
    wait_ir(4);
    checks++;
    if (ir !== mem_word(16'h0)) begin
      errors++;
      $display("FAIL restart_ir got=%h want=%h", ir, mem_word(16'h0));
    end
  endtask

  task automatic test_random();
    bit          sel;
    bit          rel;
    logic [15:0] tgt;
    for (int i = 0; i < 150; i++) begin
      delay = $urandom_range(0, 3);
      sel   = 1'($urandom_range(0, 1));
      rel   = 1'($urandom_range(0, 1));
      tgt   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) cyc();
      issue(sel, rel, tgt);
      checks++;
      if (im_req !== 1'b1 || im_addr !== exp_pc || pc !== exp_pc) begin
        errors++;
        $display("FAIL rnd_addr%0d req=%b addr=%h pc=%h want %h",
                 i, im_req, im_addr, pc, exp_pc);
      end
      wait_ir(8);
      checks++;
      if (ir !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL rnd_ir%0d got=%h want=%h", i, ir,
                 mem_word(exp_pc));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_branches();
    test_corners();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the SISC core.
- Owns the program counter (PC) and issues word-addressed reads to instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register that drives the core's 32-bit instruction input.
- Advances the PC, sequentially or by branch, only when the control unit asks for the next instruction.

Parameters:
ADDR_W, 16, width of PC and instruction-memory address (word address)
RESET_PC, 0, PC value loaded on reset
INST_W, 32, instruction width

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst_f  in  1  asynchronous active-low reset
next_req  in  1  one-cycle pulse from ctrl: current instruction retired, fetch next
br_sel  in  1  sampled with next_req: 1 = branch taken
br_rel  in  1  sampled with next_req: 1 = PC-relative, 0 = absolute
br_target  in  ADDR_W  absolute address, or two's-complement offset when br_rel=1
im_req  out  1  instruction-memory read request
im_addr  out  ADDR_W  instruction-memory read address
im_ack  in  1  memory data valid on im_data this cycle
im_data  in  INST_W  memory read data
ir  out  INST_W  instruction register, fed to the core's instruction input
ir_valid  out  1  ir holds a freshly fetched instruction for the current PC
pc  out  ADDR_W  address of the instruction in ir / being fetched

Behaviour:
- Reset: clock is clk; reset is rst_f, asynchronous and active-low.
- While rst_f=0, outputs are forced to: pc=RESET_PC, im_addr=RESET_PC, im_req=0, ir=0 (NOP), ir_valid=0, state=START.
- Reset asserted at any time, including mid-fetch, aborts immediately. A late im_ack after reset is ignored because im_req=0.
- States: START, FETCH, HOLD. All outputs are registered.
- START → FETCH on the first clk edge after rst_f releases. That edge sets im_req=1, im_addr=pc.
- FETCH: im_req=1, im_addr stable. On an edge with im_ack=1:
  - ir<=im_data, ir_valid<=1, im_req<=0.
  - Go to HOLD.
  - Unbounded wait for im_ack.
- HOLD: ir and pc stay stable. On an edge with next_req=1:
  - pc<=npc, im_addr<=npc, im_req<=1, ir_valid<=0.
  - ir keeps its old value until the new word arrives.
  - Go to FETCH.
- npc, modulo 2^ADDR_W (wrap-around, no error flag):
  - br_sel=0: pc+1
  - br_sel=1, br_rel=0: br_target
  - br_sel=1, br_rel=1: pc+1+sext(br_target)
- next_req in START or FETCH is ignored; branch inputs are sampled only in HOLD.
- im_ack while im_req=0 is ignored.
- Latency with zero-wait memory:
  - next_req at edge N → im_req high during N..N+1, ack sampled at edge N+1 → ir_valid=1 after edge N+1.
  - Two cycles per instruction minimum.
- Simultaneous next_req and im_ack in FETCH: ack is taken, next_req is dropped.
- pc=2^ADDR_W-1 with sequential advance gives pc=0.

Decomposition:
- Shared package sisc_pkg:
  - state encoding (START=2'd0, FETCH=2'd1, HOLD=2'd2)
  - NOP_INST=32'h0
  - default ADDR_W
- One combinational sub-module, fetch_npc: computes npc from pc, br_sel, br_rel, br_target. It is unit-testable in isolation.
- FSM and registers stay in fetch_unit.

Test Plan:
- Reset/start-up: hold rst_f=0 3 cycles with memory acking every cycle, then release.
  - During reset: pc=0, ir=0, im_req=0, ir_valid=0.
  - First edge after release: im_req=1, im_addr=0.
  - Next edge: ir=mem[0], ir_valid=1.
- Sequential fetch: ack in the same cycle as req, pulse next_req in each HOLD for 4 instructions. Required: im_addr sequence 0,1,2,3 with ir matching mem[0..3].
- Wait states: ack delayed 3 cycles. Required: im_req and im_addr held, ir_valid=0 until the ack edge, ir unchanged until then.
- Branches from pc=5:
  - absolute, br_target=16'h0040 → im_addr=0x40
  - relative, br_target=16'hFFFC (-4) → im_addr=2
  - relative wrap from pc=16'hFFFF with offset 0 → im_addr=0
- Corner events:
  - next_req during FETCH → ignored, im_addr unchanged.
  - Stray im_ack in HOLD → ir unchanged.
  - rst_f dropped mid-FETCH, then ack arrives → ir=0, pc=RESET_PC, fetch restarts at 0.
